instr_cache: RTL and testbench
==============================

# instr_cache

Direct-mapped, read-only instruction cache that serves the fetcher's fetch requests. It accepts a PC plus a fetch strobe and returns one instruction word tagged with its address. On a miss it issues a one-word read to the memory controller, fills the line, and then answers. It sits between the fetcher and the memory controller's instruction port, and it honours the RoB clear.

## Interface
- `INDEX_BITS`, default 6: number of lines is 2^INDEX_BITS; each line holds one 32-bit word.
- `clk` input 1: clock; all state changes on rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `rdy` input 1: global enable; when low, all state and outputs hold.
- `rob_clear` input 1: pipeline flush; aborts the current request.
- `start_fetch` input 1: fetch request, level; valid with `pc`.
- `pc` input 32: fetch address; bits [1:0] ignored.
- `instr_ready_out` output 1: one-cycle response strobe.
- `instr_out` output 32: instruction word, valid with strobe.
- `instr_addr_out` output 32: `{pc[31:2],2'b00}` of the answered request.
- `mem_req` output 1: word read request to the memory controller, level.
- `mem_addr` output 32: word-aligned read address, stable while `mem_req` is high.
- `mem_done` input 1: one-cycle pulse; `mem_data` is valid.
- `mem_data` input 32: returned word.

## Operation
- Address split:
  - index = `pc[INDEX_BITS+1:2]`
  - tag = `pc[31:INDEX_BITS+2]`
- Per-line storage: valid bit, tag, data.
  - Only valid bits are reset; tag and data arrays are not.
- States: IDLE, MISS, RESP.
- IDLE, `start_fetch`=1, `rob_clear`=0:
  - Hit (valid and tag equal): register `instr_out`/`instr_addr_out`, set `instr_ready_out`, go to RESP.
  - Miss: latch the request address, raise `mem_req` with `mem_addr`, clear the abort flag, go to MISS.
- IDLE with `rob_clear`=1: request ignored, stay IDLE.
- MISS:
  - Hold `mem_req`/`mem_addr`.
  - `rob_clear` sets the sticky abort flag. The memory read is never cancelled.
  - On `mem_done`:
    - Drop `mem_req`.
    - Write valid, tag and data into the line.
    - If not aborted and `rob_clear`=0 this cycle: present `mem_data` with the latched address, strobe, go to RESP.
    - Otherwise go to IDLE with no response.
- RESP:
  - Drop `instr_ready_out`; `start_fetch` is ignored this cycle; go to IDLE.
  - The fetcher must change `pc` or drop `start_fetch` before the next IDLE cycle, or the same word is returned again.
- `rob_clear` while `instr_ready_out` is high has no effect on the cache; the fetcher discards the word.
- `rdy`=0: no state, array, or output change; `mem_done` is not expected while `rdy`=0.
- Reset, including mid-MISS:
  - State goes to IDLE; all valid bits, `instr_ready_out`, `instr_out`, `instr_addr_out`, `mem_req`, `mem_addr` and the abort flag go to 0.
  - The memory controller is reset by the same `rst`.

## Timing
- Hit latency: the request is sampled at edge N; the strobe is high in cycle N+1 only.
- Miss latency: `mem_req` is high from cycle N+1. With `mem_done` at edge M, the strobe is high in cycle M+1.
- Best-case throughput is one response every 2 cycles (hit, RESP, hit...).
- Fill and response occur on the same edge. A request to the same line in the next IDLE cycle hits.
- `rob_clear` on the same edge as a hit lookup: no strobe, state stays IDLE.

## Configuration
- `ICACHE_EN` defined: behaviour as above.
- `ICACHE_EN` undefined:
  - Storage arrays are not built and every lookup misses.
  - Each request goes through MISS; no line is written.
  - Interface, abort and strobe timing are unchanged.
  - Used to isolate cache bugs.

## Test plan
- Reset, then `pc`=0x0000_0010 with `start_fetch`:
  - `mem_req`=1 with `mem_addr`=0x10 next cycle.
  - `mem_done` with 0x0000_0013 → one strobe, `instr_out`=0x13, `instr_addr_out`=0x10.
- Repeat fetch of 0x10 → strobe exactly 1 cycle after the request, `mem_req` stays 0 (with `ICACHE_EN`).
- Conflict: fetch 0x10, then 0x110 (INDEX_BITS=6, same index) → second is a miss, refills; refetch of 0x10 misses again.
- `rob_clear` pulse two cycles into a miss for 0x20, then `mem_done`=0xDEAD_BEEF:
  - No strobe; state returns to IDLE.
  - A later fetch of 0x20 hits with 0xDEAD_BEEF.
- `rdy`=0 for 3 cycles during MISS and during RESP → `mem_req` and the strobe hold their values, no extra or lost strobe.
- Assert `rst` mid-MISS (async, between edges):
  - Outputs go to 0 immediately.
  - A fetch of a previously cached address misses.

Source files
------------

// File: rtl/instr_cache_if.sv
// Fetch-side and memory-side signals of the instruction cache.
// The slave modport is the cache's view; the master modport drives it.
interface instr_cache_if;
  logic        rdy;
  logic        rob_clear;
  logic        start_fetch;
  logic [31:0] pc;
  logic        instr_ready_out;
  logic [31:0] instr_out;
  logic [31:0] instr_addr_out;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_done;
  logic [31:0] mem_data;

  modport slave (
    input  rdy, rob_clear, start_fetch, pc, mem_done, mem_data,
    output instr_ready_out, instr_out, instr_addr_out, mem_req, mem_addr
  );

  modport master (
    output rdy, rob_clear, start_fetch, pc, mem_done, mem_data,
    input  instr_ready_out, instr_out, instr_addr_out, mem_req, mem_addr
  );
endinterface

// File: rtl/instr_cache.sv
// Direct-mapped, read-only instruction cache with one 32-bit word per line.
// Define ICACHE_EN to build the tag/data arrays; without it every lookup misses.
module instr_cache #(
  parameter int INDEX_BITS = 6
) (
  input logic          clk,
  input logic          rst,
  instr_cache_if.slave bus
);
  localparam int Lines   = 1 << INDEX_BITS;
  localparam int TagBits = 30 - INDEX_BITS;

  typedef enum logic [1:0] {IDLE, MISS, RESP} state_e;

  state_e       state_q;
  logic         ready_q;
  logic         memReq_q;
  logic         abort_q;
  logic [31:0]  instr_q;
  logic [31:2]  instrAddr_q;
  logic [31:2]  memAddr_q;
  logic         hit;
  logic [31:0]  hitData;

  assign bus.instr_ready_out = ready_q;
  assign bus.instr_out       = instr_q;
  assign bus.instr_addr_out  = {instrAddr_q, 2'b00};
  assign bus.mem_req         = memReq_q;
  assign bus.mem_addr        = {memAddr_q, 2'b00};

`ifdef ICACHE_EN
  logic [Lines-1:0]      valid_q;
  logic [TagBits-1:0]    tagArr_q [Lines];
  logic [31:0]           dataArr_q [Lines];
  logic [INDEX_BITS-1:0] lookupIdx;
  logic [INDEX_BITS-1:0] fillIdx;
  logic                  fill;

  assign lookupIdx = bus.pc[INDEX_BITS+1:2];
  assign fillIdx   = memAddr_q[INDEX_BITS+1:2];
  assign fill      = bus.rdy && (state_q == MISS) && bus.mem_done;
  assign hit       = valid_q[lookupIdx] && (tagArr_q[lookupIdx] == bus.pc[31:INDEX_BITS+2]);
  assign hitData   = dataArr_q[lookupIdx];

  // Tag and data are left unreset; the valid bits alone decide whether they count.
  always_ff @(posedge clk) begin
    if (fill) begin
      tagArr_q[fillIdx]  <= memAddr_q[31:INDEX_BITS+2];
      dataArr_q[fillIdx] <= bus.mem_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
    end else if (fill) begin
      valid_q[fillIdx] <= 1'b1;
    end
  end
`else
  assign hit     = 1'b0;
  assign hitData = '0;
`endif

  // A flush during a miss only marks it aborted; the memory read still runs to completion.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      ready_q     <= 1'b0;
      memReq_q    <= 1'b0;
      abort_q     <= 1'b0;
      instr_q     <= '0;
      instrAddr_q <= '0;
      memAddr_q   <= '0;
    end else if (bus.rdy) begin
      case (state_q)
        IDLE: begin
          if (bus.start_fetch && !bus.rob_clear) begin
            if (hit) begin
              instr_q     <= hitData;
              instrAddr_q <= bus.pc[31:2];
              ready_q     <= 1'b1;
              state_q     <= RESP;
            end else begin
              memAddr_q <= bus.pc[31:2];
              memReq_q  <= 1'b1;
              abort_q   <= 1'b0;
              state_q   <= MISS;
            end
          end
        end
        MISS: begin
          if (bus.rob_clear) begin
            abort_q <= 1'b1;
          end
          if (bus.mem_done) begin
            memReq_q <= 1'b0;
            if (!abort_q && !bus.rob_clear) begin
              instr_q     <= bus.mem_data;
              instrAddr_q <= memAddr_q;
              ready_q     <= 1'b1;
              state_q     <= RESP;
            end else begin
              state_q <= IDLE;
            end
          end
        end
        RESP: begin
          ready_q <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_instr_cache.sv
// Directed bench for instr_cache: expected responses go into a scoreboard queue
// and are popped by a monitor whenever the cache raises a new response strobe.
module tb_instr_cache;
  localparam int IndexBits = 6;
  localparam int Lines     = 1 << IndexBits;
`ifdef ICACHE_EN
  localparam bit CacheOn = 1'b1;
`else
  localparam bit CacheOn = 1'b0;
`endif

  typedef struct packed {
    logic [31:0] data;
    logic [31:0] addr;
  } resp_t;

  logic clk = 1'b0;
  logic rst;

  instr_cache_if bus ();

  instr_cache #(.INDEX_BITS(IndexBits)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int    checks = 0;
  int    errors = 0;
  resp_t sbQ[$];
  resp_t sbHead;
  logic  modelValid [Lines];
  logic [31:0] modelAddr [Lines];
  logic [31:0] modelData [Lines];
  logic  edgeRdy   = 1'b1;
  logic  prevReady = 1'b0;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic sf, input logic rc, input logic [31:0] pcv);
    bus.start_fetch = sf;
    bus.rob_clear   = rc;
    bus.pc          = pcv;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int idxOf(input logic [31:0] a);
    return int'(a[IndexBits+1:2]);
  endfunction

  function automatic bit predictHit(input logic [31:0] pcv);
    int i;
    i = idxOf(pcv);
    return CacheOn && modelValid[i] && (modelAddr[i] == {pcv[31:2], 2'b00});
  endfunction

  task automatic modelFill(input logic [31:0] a, input logic [31:0] d);
    int i;
    i = idxOf(a);
    modelValid[i] = 1'b1;
    modelAddr[i]  = {a[31:2], 2'b00};
    modelData[i]  = d;
  endtask

  // Hold on a stalled strobe is the same response, not a new one.
  always @(posedge clk) edgeRdy = bus.rdy;

  always @(negedge clk) begin
    if (bus.instr_ready_out === 1'b1 && !(prevReady && !edgeRdy)) begin
      checkOutput("strobeExpected", {31'd0, sbQ.size() != 0}, 32'd1);
      if (sbQ.size() != 0) begin
        sbHead = sbQ.pop_front();
        checkOutput("respData", bus.instr_out, sbHead.data);
        checkOutput("respAddr", bus.instr_addr_out, sbHead.addr);
      end
    end
    prevReady = bus.instr_ready_out;
  end

  // Full fetch: hit path if the model predicts one, otherwise a miss served with memWord.
  task automatic fetchWord(input logic [31:0] pcv, input logic [31:0] memWord);
    logic [31:0] aligned;
    bit          hitExp;
    aligned = {pcv[31:2], 2'b00};
    hitExp  = predictHit(pcv);
    if (hitExp) sbQ.push_back('{data: modelData[idxOf(pcv)], addr: aligned});
    applyStimulus(1'b1, 1'b0, pcv);
    tick();
    applyStimulus(1'b0, 1'b0, pcv);
    if (hitExp) begin
      checkOutput("hitStrobe", {31'd0, bus.instr_ready_out}, 32'd1);
      checkOutput("hitNoMemReq", {31'd0, bus.mem_req}, 32'd0);
      tick();
      checkOutput("hitStrobeDrop", {31'd0, bus.instr_ready_out}, 32'd0);
    end else begin
      checkOutput("missReq", {31'd0, bus.mem_req}, 32'd1);
      checkOutput("missAddr", bus.mem_addr, aligned);
      checkOutput("missNoStrobe", {31'd0, bus.instr_ready_out}, 32'd0);
      tick();
      sbQ.push_back('{data: memWord, addr: aligned});
      bus.mem_done = 1'b1;
      bus.mem_data = memWord;
      tick();
      bus.mem_done = 1'b0;
      checkOutput("fillStrobe", {31'd0, bus.instr_ready_out}, 32'd1);
      checkOutput("fillReqDrop", {31'd0, bus.mem_req}, 32'd0);
      modelFill(pcv, memWord);
      tick();
      checkOutput("fillStrobeDrop", {31'd0, bus.instr_ready_out}, 32'd0);
    end
  endtask

  initial begin
    for (int i = 0; i < Lines; i++) modelValid[i] = 1'b0;
    rst          = 1'b1;
    bus.rdy      = 1'b1;
    bus.mem_done = 1'b0;
    bus.mem_data = '0;
    applyStimulus(1'b0, 1'b0, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    checkOutput("rstStrobe", {31'd0, bus.instr_ready_out}, 32'd0);
    checkOutput("rstMemReq", {31'd0, bus.mem_req}, 32'd0);
    checkOutput("rstMemAddr", bus.mem_addr, 32'd0);
    checkOutput("rstInstr", bus.instr_out, 32'd0);
    checkOutput("rstInstrAddr", bus.instr_addr_out, 32'd0);

    // Cold miss, repeat hit (low pc bits ignored), then a same-index conflict.
    fetchWord(32'h0000_0010, 32'h0000_0013);
    fetchWord(32'h0000_0011, 32'h0000_0013);
    fetchWord(32'h0000_0110, 32'hCAFE_0110);
    fetchWord(32'h0000_0010, 32'h0000_0013);

    // Flush two cycles into a miss: fill still happens, no response.
    applyStimulus(1'b1, 1'b0, 32'h0000_0020);
    tick();
    checkOutput("abortMissReq", {31'd0, bus.mem_req}, 32'd1);
    applyStimulus(1'b0, 1'b0, 32'h0000_0020);
    tick();
    applyStimulus(1'b0, 1'b1, 32'h0000_0020);
    tick();
    applyStimulus(1'b0, 1'b0, 32'h0000_0020);
    checkOutput("abortReqHeld", {31'd0, bus.mem_req}, 32'd1);
    tick();
    bus.mem_done = 1'b1;
    bus.mem_data = 32'hDEAD_BEEF;
    tick();
    bus.mem_done = 1'b0;
    checkOutput("abortNoStrobe", {31'd0, bus.instr_ready_out}, 32'd0);
    checkOutput("abortReqDrop", {31'd0, bus.mem_req}, 32'd0);
    modelFill(32'h0000_0020, 32'hDEAD_BEEF);
    tick();
    checkOutput("abortIdle", {31'd0, bus.instr_ready_out}, 32'd0);

    // Flush on the lookup edge suppresses the request entirely.
    applyStimulus(1'b1, 1'b1, 32'h0000_0020);
    tick();
    applyStimulus(1'b0, 1'b0, 32'h0000_0020);
    checkOutput("clrLookupStrobe", {31'd0, bus.instr_ready_out}, 32'd0);
    checkOutput("clrLookupMemReq", {31'd0, bus.mem_req}, 32'd0);
    fetchWord(32'h0000_0020, 32'hDEAD_BEEF);

    // Stall for three cycles in MISS and again in RESP.
    applyStimulus(1'b1, 1'b0, 32'h0000_0044);
    tick();
    applyStimulus(1'b0, 1'b0, 32'h0000_0044);
    checkOutput("stallMissReq", {31'd0, bus.mem_req}, 32'd1);
    bus.rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput("stallMissReqHold", {31'd0, bus.mem_req}, 32'd1);
      checkOutput("stallMissAddrHold", bus.mem_addr, 32'h0000_0044);
      checkOutput("stallMissNoStrobe", {31'd0, bus.instr_ready_out}, 32'd0);
    end
    bus.rdy = 1'b1;
    sbQ.push_back('{data: 32'h1234_5678, addr: 32'h0000_0044});
    bus.mem_done = 1'b1;
    bus.mem_data = 32'h1234_5678;
    tick();
    bus.mem_done = 1'b0;
    bus.rdy      = 1'b0;
    checkOutput("stallRespStrobe", {31'd0, bus.instr_ready_out}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput("stallRespHold", {31'd0, bus.instr_ready_out}, 32'd1);
      checkOutput("stallRespNoReq", {31'd0, bus.mem_req}, 32'd0);
    end
    bus.rdy = 1'b1;
    modelFill(32'h0000_0044, 32'h1234_5678);
    tick();
    checkOutput("stallRespDrop", {31'd0, bus.instr_ready_out}, 32'd0);

    // Asynchronous reset in the middle of a miss clears outputs and the cache.
    applyStimulus(1'b1, 1'b0, 32'h0000_0080);
    tick();
    applyStimulus(1'b0, 1'b0, 32'h0000_0080);
    checkOutput("preRstMemReq", {31'd0, bus.mem_req}, 32'd1);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("midRstMemReq", {31'd0, bus.mem_req}, 32'd0);
    checkOutput("midRstMemAddr", bus.mem_addr, 32'd0);
    checkOutput("midRstStrobe", {31'd0, bus.instr_ready_out}, 32'd0);
    checkOutput("midRstInstr", bus.instr_out, 32'd0);
    checkOutput("midRstInstrAddr", bus.instr_addr_out, 32'd0);
    rst = 1'b0;
    for (int i = 0; i < Lines; i++) modelValid[i] = 1'b0;
    tick();
    fetchWord(32'h0000_0010, 32'h0000_0013);

    tick();
    checkOutput("sbDrained", sbQ.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
